// File: rtl/adc_sample_filter.sv
// Periodic ADC sampler: issues a start-of-conversion pulse every SOC_PERIOD cycles,
// accumulates 2^AVG_LOG2 results and publishes their truncated mean on V_OUT.
module adc_sample_filter #(
    parameter int SOC_PERIOD  = 2200,
    parameter int AVG_LOG2    = 3,
    parameter int EOC_TIMEOUT = 1000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ADC_EOC,
    input  logic [11:0] ADC_DATA,
    output logic        ADC_SOC,
    output logic [11:0] V_OUT,
    output logic        V_VALID,
    output logic        TIMEOUT_ERR
);

    localparam int DATA_W = 12;
    localparam int ACC_W  = DATA_W + AVG_LOG2;
    localparam int IDX_W  = AVG_LOG2 + 1;
    localparam int PER_W  = $clog2(SOC_PERIOD + 1);
    localparam int TMO_W  = $clog2(EOC_TIMEOUT + 1);

    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SOC_PERIOD - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(EOC_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_EOC = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t              state_q;
    logic [PER_W-1:0]    per_q;
    logic [TMO_W-1:0]    tmo_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_d;
    logic [IDX_W-1:0]    idx_q;
    logic                tick;
    logic                soc_q;
    logic [DATA_W-1:0]   vout_q;
    logic                vvalid_q;
    logic                err_q;

    // Mean of the accumulated samples, truncated toward zero.
    function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
        logic [ACC_W-1:0] shifted;
        shifted = sum >> AVG_LOG2;
        return shifted[DATA_W-1:0];
    endfunction

    assign tick  = (per_q == PER_LAST);
    assign acc_d = acc_q + ACC_W'(ADC_DATA);

    always_ff @(posedge CLK) begin
        if (RST || tick) begin
            per_q <= '0;
        end else begin
            per_q <= per_q + PER_W'(1);
        end
    end

    // V_OUT/V_VALID are registered on the accepting edge of the last sample so the
    // strobe is visible while the FSM sits in DONE, one cycle after that ADC_EOC.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            tmo_q    <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            soc_q    <= 1'b0;
            vout_q   <= '0;
            vvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            soc_q    <= 1'b0;
            vvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        soc_q   <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= WAIT_EOC;
                    end
                end
                WAIT_EOC: begin
                    if (ADC_EOC) begin
                        acc_q <= acc_d;
                        idx_q <= idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
                            vout_q   <= avg_trunc(acc_d);
                            vvalid_q <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                DONE: begin
                    acc_q   <= '0;
                    idx_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ADC_SOC     = soc_q;
    assign V_OUT       = vout_q;
    assign V_VALID     = vvalid_q;
    assign TIMEOUT_ERR = err_q;

endmodule
